// File: rtl/pwm_dec_pkg.sv
// Shared types and default widths for the PWM duty decoder.
package pwm_dec_pkg;

    localparam int DEF_CNT_W  = 16;
    localparam int DEF_DUTY_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } dec_state_t;

endpackage

// File: rtl/duty_divider.sv
// Restoring divider: quotient = floor(dividend * 2^DUTY_W / divisor), dividend < divisor.
module duty_divider
    import pwm_dec_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int DUTY_W = DEF_DUTY_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              abort,
    input  logic              start,
    input  logic [CNT_W-1:0]  dividend,
    input  logic [CNT_W-1:0]  divisor,
    output logic              busy,
    output logic              done,
    output logic [DUTY_W-1:0] quotient
);

    // Handshake: start is taken only while busy is low; busy then stays high for
    // DUTY_W cycles, and done pulses once with quotient valid. abort drops it silently.
    localparam int IW = $clog2(DUTY_W + 1);

    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] dsr;
    logic [CNT_W:0]   rem_sh;
    logic [IW-1:0]    iter;
    logic             ge;

    assign rem_sh = {rem, 1'b0};
    assign ge     = (rem_sh >= {1'b0, dsr});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            dsr      <= '0;
            iter     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            quotient <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                busy <= 1'b0;
                iter <= '0;
            end else if (start && !busy) begin
                busy     <= 1'b1;
                rem      <= dividend;
                dsr      <= divisor;
                quotient <= '0;
                iter     <= IW'(DUTY_W);
            end else if (busy) begin
                rem      <= ge ? CNT_W'(rem_sh - {1'b0, dsr}) : rem_sh[CNT_W-1:0];
                quotient <= {quotient[DUTY_W-2:0], ge};
                iter     <= iter - 1'b1;
                if (iter == IW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pwm_duty_decoder.sv
// Recovers duty, period and high time from an asynchronous PWM stream.
// Optional 3-sample majority glitch filter: define PWM_DEC_GLITCH_FILTER_EN.
module pwm_duty_decoder
    import pwm_dec_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int DUTY_W  = DEF_DUTY_W,
    parameter int TIMEOUT = 2**CNT_W - 1
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic              Enable,
    input  logic              Pulse,
    output logic [DUTY_W-1:0] duty,
    output logic [CNT_W-1:0]  period,
    output logic [CNT_W-1:0]  high_time,
    output logic              duty_valid,
    output logic              overrun,
    output logic              timeout,
    output logic              level,
    output dec_state_t        state_dbg
);

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    logic sync_1, sync_2, pulse_s, pulse_q;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= Pulse;
            sync_2 <= sync_1;
        end
    end

`ifdef PWM_DEC_GLITCH_FILTER_EN
    logic [1:0] hist;
    logic       filt;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
            filt <= 1'b0;
        end else begin
            hist <= {hist[0], sync_2};
            filt <= (sync_2 & hist[0]) | (sync_2 & hist[1]) | (hist[0] & hist[1]);
        end
    end
    assign pulse_s = filt;
`else
    assign pulse_s = sync_2;
`endif

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) pulse_q <= 1'b0;
        else        pulse_q <= pulse_s;
    end

    logic rise, fall;
    assign rise = pulse_s & ~pulse_q;
    assign fall = ~pulse_s & pulse_q;

    dec_state_t       state;
    logic [CNT_W-1:0] hi_cnt, lo_cnt, meas_period, meas_high;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] sum_sat;
    logic             div_start, div_busy, div_done;
    logic [DUTY_W-1:0] div_q;
    logic             div_engaged;

    assign sum         = {1'b0, hi_cnt} + {1'b0, lo_cnt};
    assign sum_sat     = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    // The result stays pending in meas_* until duty_valid, so done also counts as busy.
    assign div_engaged = div_start | div_busy | div_done;
    assign state_dbg   = state;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hi_cnt      <= '0;
            lo_cnt      <= '0;
            meas_period <= '0;
            meas_high   <= '0;
            div_start   <= 1'b0;
            duty        <= '0;
            period      <= '0;
            high_time   <= '0;
            duty_valid  <= 1'b0;
            overrun     <= 1'b0;
            timeout     <= 1'b0;
            level       <= 1'b0;
        end else begin
            duty_valid <= 1'b0;
            overrun    <= 1'b0;
            timeout    <= 1'b0;
            div_start  <= 1'b0;
            if (!Enable) begin
                state  <= IDLE;
                hi_cnt <= '0;
                lo_cnt <= '0;
            end else begin
                if (div_done) begin
                    duty_valid <= 1'b1;
                    duty       <= div_q;
                    period     <= meas_period;
                    high_time  <= meas_high;
                end
                case (state)
                    IDLE: begin
                        if (rise) begin
                            state  <= HIGH;
                            hi_cnt <= CNT_W'(1);
                            lo_cnt <= '0;
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            state  <= LOW;
                            lo_cnt <= CNT_W'(1);
                        end else if (hi_cnt == TO_CNT) begin
                            state   <= IDLE;
                            timeout <= 1'b1;
                            level   <= pulse_s;
                            hi_cnt  <= '0;
                            lo_cnt  <= '0;
                        end else begin
                            hi_cnt <= hi_cnt + CNT_W'(1);
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            if (div_engaged) begin
                                overrun <= 1'b1;
                            end else begin
                                meas_period <= sum_sat;
                                meas_high   <= hi_cnt;
                                div_start   <= 1'b1;
                            end
                            state  <= HIGH;
                            hi_cnt <= CNT_W'(1);
                            lo_cnt <= '0;
                        end else if (lo_cnt == TO_CNT) begin
                            state   <= IDLE;
                            timeout <= 1'b1;
                            level   <= pulse_s;
                            hi_cnt  <= '0;
                            lo_cnt  <= '0;
                        end else begin
                            lo_cnt <= lo_cnt + CNT_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    duty_divider #(
        .CNT_W  (CNT_W),
        .DUTY_W (DUTY_W)
    ) u_div (
        .clk      (sysclk),
        .rst_n    (rst_n),
        .abort    (~Enable),
        .start    (div_start),
        .dividend (meas_high),
        .divisor  (meas_period),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q)
    );

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Randomised and directed bench for pwm_duty_decoder against a cycle-level waveform model.
module tb_pwm_duty_decoder;
    import pwm_dec_pkg::*;

    localparam int CNT_W   = 16;
    localparam int DUTY_W  = 8;
    localparam int TIMEOUT = 100;
`ifdef PWM_DEC_GLITCH_FILTER_EN
    localparam int SD  = 4;
    localparam int HI2 = 254;
    localparam int LO2 = 2;
`else
    localparam int SD  = 2;
    localparam int HI2 = 255;
    localparam int LO2 = 1;
`endif
    localparam int EW = 32 + DUTY_W + 2 * CNT_W;

    // clock / reset
    logic sysclk = 1'b0;
    logic rst_n  = 1'b0;
    logic Enable = 1'b0;
    logic Pulse  = 1'b0;
    int   cyc    = 0;

    initial forever #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    logic [DUTY_W-1:0] duty, l_duty;
    logic [CNT_W-1:0]  period, high_time, l_period, l_high_time;
    logic              duty_valid, overrun, timeout, level;
    logic              l_duty_valid, l_overrun, l_timeout, l_level;
    dec_state_t        state_dbg, l_state_dbg;

    pwm_duty_decoder #(.CNT_W(CNT_W), .DUTY_W(DUTY_W), .TIMEOUT(TIMEOUT)) u_dut (
        .sysclk(sysclk), .rst_n(rst_n), .Enable(Enable), .Pulse(Pulse),
        .duty(duty), .period(period), .high_time(high_time),
        .duty_valid(duty_valid), .overrun(overrun), .timeout(timeout),
        .level(level), .state_dbg(state_dbg)
    );

    pwm_duty_decoder #(.CNT_W(CNT_W), .DUTY_W(DUTY_W)) u_long (
        .sysclk(sysclk), .rst_n(rst_n), .Enable(Enable), .Pulse(Pulse),
        .duty(l_duty), .period(l_period), .high_time(l_high_time),
        .duty_valid(l_duty_valid), .overrun(l_overrun), .timeout(l_timeout),
        .level(l_level), .state_dbg(l_state_dbg)
    );

    // scoreboard
    int n_checks = 0;
    int n_fail   = 0;
    logic [EW-1:0] exp_q[$];
    logic [31:0]   ovr_q[$];
    logic [32:0]   to_q[$];
    logic [EW-1:0] mon_e;
    logic [32:0]   mon_t;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // waveform model state
    bit                chain = 1'b0;
    int                rise_k = 0, fall_k = 0, busy_until = 0;
    int                n_ovr_mdl = 0, n_ovr_seen = 0;
    logic [DUTY_W-1:0] last_duty = '0;
    logic [CNT_W-1:0]  last_period = '0, last_high = '0;

    // Called just before Pulse takes level lvl for n cycles.
    task automatic model_seg(input logic lvl, input int n);
        int k, t, per, hi;
        k = cyc + 1;
        t = k + SD;
        if (lvl && chain) begin
            per = k - rise_k;
            hi  = fall_k - rise_k;
            if (t > busy_until) begin
                exp_q.push_back({32'(t + DUTY_W + 2), DUTY_W'((hi << DUTY_W) / per),
                                 CNT_W'(per), CNT_W'(hi)});
                busy_until = t + DUTY_W + 2;
            end else begin
                ovr_q.push_back(32'(t));
                n_ovr_mdl++;
            end
        end
        if (lvl) begin
            rise_k = k;
            chain  = 1'b1;
        end else begin
            fall_k = k;
        end
        if (chain && n > TIMEOUT) begin
            to_q.push_back({32'(t + TIMEOUT), lvl});
            chain = 1'b0;
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        ovr_q.delete();
        to_q.delete();
        chain      = 1'b0;
        busy_until = 0;
    endtask

    // driver tasks (entered on a falling clock edge)
    task automatic drive(input logic lvl, input int n);
        model_seg(lvl, n);
        Pulse = lvl;
        repeat (n) @(negedge sysclk);
    endtask

`ifdef PWM_DEC_GLITCH_FILTER_EN
    task automatic drive_low_glitch();
        model_seg(1'b0, 15);
        Pulse = 1'b0;
        repeat (6) @(negedge sysclk);
        Pulse = 1'b1;
        @(negedge sysclk);
        Pulse = 1'b0;
        repeat (8) @(negedge sysclk);
    endtask
`endif

    task automatic run_std(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 5);
            drive(1'b0, 15);
        end
    endtask

    // monitor
    always @(negedge sysclk) begin
        if (rst_n) begin
            if (duty_valid) begin
                if (exp_q.size() == 0) begin
                    check("dv_unexpected", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("dv_cycle", cyc, mon_e[EW-1 -: 32]);
                    check("duty", duty, mon_e[2*CNT_W +: DUTY_W]);
                    check("period", period, mon_e[CNT_W +: CNT_W]);
                    check("high_time", high_time, mon_e[0 +: CNT_W]);
                    last_duty   = mon_e[2*CNT_W +: DUTY_W];
                    last_period = mon_e[CNT_W +: CNT_W];
                    last_high   = mon_e[0 +: CNT_W];
                end
            end else if (exp_q.size() != 0 && int'(exp_q[0][EW-1 -: 32]) < cyc) begin
                check("dv_missing", cyc, exp_q[0][EW-1 -: 32]);
                void'(exp_q.pop_front());
            end

            if (overrun) begin
                n_ovr_seen++;
                if (ovr_q.size() == 0) check("ovr_unexpected", 1, 0);
                else check("ovr_cycle", cyc, ovr_q.pop_front());
            end else if (ovr_q.size() != 0 && int'(ovr_q[0]) < cyc) begin
                check("ovr_missing", cyc, ovr_q[0]);
                void'(ovr_q.pop_front());
            end

            if (timeout) begin
                if (to_q.size() == 0) begin
                    check("to_unexpected", 1, 0);
                end else begin
                    mon_t = to_q.pop_front();
                    check("to_cycle", cyc, mon_t[32:1]);
                    check("to_level", level, mon_t[0]);
                end
            end else if (to_q.size() != 0 && int'(to_q[0][32:1]) < cyc) begin
                check("to_missing", cyc, to_q[0][32:1]);
                void'(to_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, expected finish by cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int ovr0;
        @(negedge sysclk);
        @(negedge sysclk);
        check("rst_duty", duty, 0);
        check("rst_period", period, 0);
        check("rst_high", high_time, 0);
        check("rst_dv", duty_valid, 0);
        check("rst_ovr", overrun, 0);
        check("rst_to", timeout, 0);
        check("rst_level", level, 0);
        rst_n  = 1'b1;
        Enable = 1'b1;
        repeat (3) @(negedge sysclk);

        // steady 20/5 stream
        run_std(8);
        check("r35_duty", duty, 64);
        check("r35_period", period, 20);
        check("r35_high", high_time, 5);

        // period 6: alternate overruns
        ovr0 = n_ovr_seen;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2);
            drive(1'b0, 4);
        end
        run_std(2);
        check("r37_ovr_count", n_ovr_seen - ovr0, n_ovr_mdl);

        // high level stuck beyond the timeout
        drive(1'b1, 130);
        check("r38_level", level, 1);
        drive(1'b0, 20);
        run_std(3);
        check("r38_duty", duty, 64);

        // Enable dropped mid-division
        drive(1'b1, 5);
        drive(1'b0, 9);
        model_seg(1'b1, 5);
        Pulse = 1'b1;
        repeat (4) @(negedge sysclk);
        Enable = 1'b0;
        Pulse  = 1'b0;
        model_clear();
        repeat (16) @(negedge sysclk);
        check("en_hold_duty", duty, last_duty);
        check("en_hold_period", period, last_period);
        check("en_hold_high", high_time, last_high);
        Enable = 1'b1;
        repeat (3) @(negedge sysclk);
        drive(1'b1, 4);
        drive(1'b0, 12);
        drive(1'b1, 4);
        drive(1'b0, 12);
        check("en_after_duty", duty, 64);
        check("en_after_period", period, 16);

        // reset dropped mid-division
        model_seg(1'b1, 5);
        Pulse = 1'b1;
        repeat (4) @(negedge sysclk);
        rst_n = 1'b0;
        Pulse = 1'b0;
        model_clear();
        last_duty   = '0;
        last_period = '0;
        last_high   = '0;
        repeat (3) @(negedge sysclk);
        check("mid_rst_duty", duty, 0);
        check("mid_rst_period", period, 0);
        check("mid_rst_high", high_time, 0);
        check("mid_rst_level", level, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge sysclk);
        drive(1'b1, 10);
        drive(1'b0, 30);
        drive(1'b1, 10);
        drive(1'b0, 30);
        check("rst_after_duty", duty, 64);
        check("rst_after_period", period, 40);

        // long periods on the default-timeout instance
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 128);
            drive(1'b0, 128);
        end
        check("r36_duty_half", l_duty, 128);
        check("r36_period_half", l_period, 256);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, HI2);
            drive(1'b0, LO2);
        end
        drive(1'b1, 20);
        check("r36_duty_max", l_duty, (HI2 << DUTY_W) / (HI2 + LO2));
        check("r36_high_max", l_high_time, HI2);
        drive(1'b0, 20);

`ifdef PWM_DEC_GLITCH_FILTER_EN
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5);
            drive_low_glitch();
        end
        drive(1'b1, 5);
        drive(1'b0, 15);
        check("glitch_period", period, 20);
        check("glitch_duty", duty, 64);
`endif

        // randomised segments
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, $urandom_range(30, 2));
            drive(1'b0, $urandom_range(30, 2));
        end
        drive(1'b1, 5);
        drive(1'b0, 150);
        check("end_level", level, 0);
        check("exp_q_left", exp_q.size(), 0);
        check("ovr_q_left", ovr_q.size(), 0);
        check("to_q_left", to_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
